// File: rtl/rom_ctrl.sv
// rom_ctrl: two-requester round-robin read controller for a 32-word asynchronous ROM.
// Optional one-entry read cache is compiled in when ROM_CTRL_CACHE_EN is defined.
module rom_ctrl #(
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 8,
  parameter int unsigned WAIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          rom_cs,
  output logic          rom_oe,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  localparam int unsigned CW = 4;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          last, last_d;
  logic          owner, owner_d;
  logic          ack0_d, ack1_d;
  logic          rom_cs_d, rom_oe_d;
  logic [DW-1:0] rdata_d;
  logic [AW-1:0] rom_addr_d;
  logic          win_c;
  logic [AW-1:0] win_addr_c;
  logic          hit_c;
`ifdef ROM_CTRL_CACHE_EN
  logic          c_vld, c_vld_d;
  logic [AW-1:0] c_tag, c_tag_d;
  logic [DW-1:0] c_data, c_data_d;
`endif

  // A lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    win_c      = (req0 && req1) ? ~last : req1;
    win_addr_c = win_c ? addr1 : addr0;
`ifdef ROM_CTRL_CACHE_EN
    hit_c      = c_vld && (c_tag == win_addr_c);
`else
    hit_c      = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    last_d     = last;
    owner_d    = owner;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata_d    = rdata;
    rom_cs_d   = rom_cs;
    rom_oe_d   = rom_oe;
    rom_addr_d = rom_addr;
`ifdef ROM_CTRL_CACHE_EN
    c_vld_d    = c_vld;
    c_tag_d    = c_tag;
    c_data_d   = c_data;
`endif
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          last_d  = win_c;
          owner_d = win_c;
          if (hit_c) begin
`ifdef ROM_CTRL_CACHE_EN
            rdata_d = c_data;
`endif
            ack0_d  = ~win_c;
            ack1_d  = win_c;
            state_d = DONE;
          end else begin
            rom_addr_d = win_addr_c;
            rom_cs_d   = 1'b0;
            rom_oe_d   = 1'b1;
            cnt_d      = CW'(WAIT - 1);
            state_d    = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          // Only capture while the ROM is actually driving the bus.
          if (!rom_cs && rom_oe) begin
            rdata_d = rom_data;
`ifdef ROM_CTRL_CACHE_EN
            c_vld_d  = 1'b1;
            c_tag_d  = rom_addr;
            c_data_d = rom_data;
`endif
          end
          ack0_d   = ~owner;
          ack1_d   = owner;
          rom_cs_d = 1'b1;
          rom_oe_d = 1'b0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      owner    <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= '0;
      rom_cs   <= 1'b1;
      rom_oe   <= 1'b0;
      rom_addr <= '0;
`ifdef ROM_CTRL_CACHE_EN
      c_vld    <= 1'b0;
      c_tag    <= '0;
      c_data   <= '0;
`endif
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      last     <= last_d;
      owner    <= owner_d;
      ack0     <= ack0_d;
      ack1     <= ack1_d;
      rdata    <= rdata_d;
      rom_cs   <= rom_cs_d;
      rom_oe   <= rom_oe_d;
      rom_addr <= rom_addr_d;
`ifdef ROM_CTRL_CACHE_EN
      c_vld    <= c_vld_d;
      c_tag    <= c_tag_d;
      c_data   <= c_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_rom_ctrl.sv
// tb_rom_ctrl: two controller instances (WAIT=1 and WAIT=3) against a transaction-level
// model of arbitration, latency, ROM enable window and the optional one-entry cache.
module tb_rom_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0[2];
  logic       req1[2];
  logic [4:0] addr0[2];
  logic [4:0] addr1[2];
  logic       ack0[2];
  logic       ack1[2];
  logic [7:0] rdata[2];
  logic       rom_cs[2];
  logic       rom_oe[2];
  logic [4:0] rom_addr[2];

  int checks = 0;
  int errors = 0;

  // Reference state: who was served last, and the cached address per instance.
  bit         m_last[2];
  bit         c_vld[2];
  logic [4:0] c_tag[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wire [7:0] bus;
    assign bus = (!rom_cs[g] && rom_oe[g]) ? (8'(rom_addr[g]) ^ 8'hA5) : 8'hzz;
    rom_ctrl #(.AW(5), .DW(8), .WAIT((g == 0) ? 1 : 3)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0[g]),
      .req1     (req1[g]),
      .addr0    (addr0[g]),
      .addr1    (addr1[g]),
      .ack0     (ack0[g]),
      .ack1     (ack1[g]),
      .rdata    (rdata[g]),
      .rom_cs   (rom_cs[g]),
      .rom_oe   (rom_oe[g]),
      .rom_addr (rom_addr[g]),
      .rom_data (bus)
    );
  end

  function automatic logic [7:0] rom_word(input logic [4:0] a);
    return 8'(a) ^ 8'hA5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction; entered just after an edge with the controller idle.
  // mode 0: hold REQs afterwards, 1: drop after ACK, 2: drop right after the grant.
  task automatic txn(input int d, input bit r0, input bit r1,
                     input logic [4:0] a0, input logic [4:0] a1, input int mode);
    bit         w;
    bit         hit;
    bit         got;
    logic [4:0] a;
    int         k;
    int         en;
    int         wt;
    wt = (d == 0) ? 1 : 3;
    req0[d] = r0; req1[d] = r1; addr0[d] = a0; addr1[d] = a1;
    w   = (r0 && r1) ? !m_last[d] : r1;
    a   = w ? a1 : a0;
    hit = 1'b0;
`ifdef ROM_CTRL_CACHE_EN
    hit = c_vld[d] && (c_tag[d] == a);
`endif
    k = 0; en = 0; got = 1'b0;
    while (!got && k < 24) begin
      @(posedge clk); #1;
      k++;
      if (mode == 2 && k == 1) begin
        req0[d] = 1'b0; req1[d] = 1'b0;
      end
      chk("cs_oe_pair", rom_oe[d], !rom_cs[d]);
      if (!rom_cs[d] && rom_oe[d]) begin
        en++;
        chk("rom_addr", rom_addr[d], a);
      end
      got = ack0[d] || ack1[d];
    end
    chk("ack_seen", got, 1);
    chk("latency", k, hit ? 1 : wt + 1);
    chk("rom_en_cycles", en, hit ? 0 : wt);
    chk("ack0", ack0[d], !w);
    chk("ack1", ack1[d], w);
    chk("rdata", rdata[d], rom_word(a));
    m_last[d] = w;
    if (!hit) begin
      c_vld[d] = 1'b1; c_tag[d] = a;
    end
    if (mode != 0) begin
      req0[d] = 1'b0; req1[d] = 1'b0;
    end
    @(posedge clk); #1;
    chk("ack_pulse", {ack0[d], ack1[d]}, 2'b00);
    chk("rdata_hold", rdata[d], rom_word(a));
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 1'b1; c_vld[d] = 1'b0; c_tag[d] = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req0[d] = 1'b1; req1[d] = 1'b0; addr0[d] = 5'd3; addr1[d] = '0;
    end
    model_reset();

    // Reset held with a pending request: ROM stays disabled, nothing returned.
    repeat (3) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        chk("rst_cs", rom_cs[d], 1);
        chk("rst_oe", rom_oe[d], 0);
        chk("rst_ack0", ack0[d], 0);
        chk("rst_rdata", rdata[d], 0);
        chk("rst_rom_addr", rom_addr[d], 0);
      end
    end
    rst_n = 1'b1;

    // Contention from reset: grants 0,1,0,1 with both held.
    for (int i = 0; i < 4; i++) txn(0, 1'b1, 1'b1, 5'd1, 5'd2, (i == 3) ? 1 : 0);
    txn(0, 1'b1, 1'b0, 5'd3, 5'd0, 1);
    txn(1, 1'b0, 1'b1, 5'd0, 5'd31, 1);

    // Asynchronous reset during the second ACCESS cycle of a WAIT=3 read.
    req0[1] = 1'b0; req1[1] = 1'b1; addr1[1] = 5'd29;
    @(posedge clk); #1;
    chk("mid_en1", rom_cs[1], 0);
    @(posedge clk); #1;
    chk("mid_en2", rom_oe[1], 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", rom_cs[1], 1);
    chk("mid_rst_oe", rom_oe[1], 0);
    chk("mid_rst_ack1", ack1[1], 0);
    chk("mid_rst_rdata", rdata[1], 0);
    req1[1] = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_no_ack", {ack0[1], ack1[1]}, 2'b00);
      chk("mid_rst_cs_hold", rom_cs[1], 1);
    end
    rst_n = 1'b1;
    txn(1, 1'b1, 1'b1, 5'd4, 5'd5, 1);
    txn(0, 1'b1, 1'b1, 5'd6, 5'd10, 1);

    // Repeated address (cache hit when enabled), then a new address.
    txn(0, 1'b1, 1'b0, 5'd7, 5'd0, 1);
    txn(0, 1'b1, 1'b0, 5'd7, 5'd0, 1);
    txn(0, 1'b1, 1'b0, 5'd8, 5'd0, 1);

    // REQ dropped right after the grant still completes.
    txn(1, 1'b1, 1'b0, 5'd9, 5'd0, 2);
    txn(1, 1'b0, 1'b1, 5'd0, 5'd17, 2);

    // Randomized traffic over a small address range to exercise repeats.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 25; i++) begin
        bit r0;
        bit r1;
        int mode;
        r0   = 1'($urandom_range(0, 1));
        r1   = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
        mode = int'($urandom_range(0, 2));
        txn(d, r0, r1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), mode);
        if (mode != 0) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            chk("idle_cs", rom_cs[d], 1);
            chk("idle_ack", {ack0[d], ack1[d]}, 2'b00);
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
